ps2_scan_ctrl: RTL and testbench
================================

Name: ps2_scan_ctrl

Overview:
Sequencer that sits between the PS/2 frame receiver and the rest of the keyboard path.
- Gates the receiver's `enable_rx` for flow control.
- Consumes each received byte on the `rx_listo` pulse.
- Folds E0/F0 prefix bytes into single key events: code + extended flag + break flag.
- Buffers events in a small FIFO drained by a valid/ready consumer (display/command logic).

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYC, 2_000_000, clk cycles allowed between a prefix byte and its follow-up byte (20 ms at 100 MHz).
- TO_W, 21, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx_listo  in  1  one-cycle pulse from the receiver: a byte is valid on codigo_tecla.
- codigo_tecla  in  8  received scan byte.
- enable_rx  out  1  permits the receiver to start a new frame.
- ev_valid  out  1  an event is available at the FIFO head.
- ev_ready  in  1  consumer accepts the head event.
- ev_code  out  8  head event scan code.
- ev_ext  out  1  head event was E0-prefixed.
- ev_brk  out  1  head event is a release (F0-prefixed).
- err_timeout  out  1  one-cycle pulse: prefix sequence abandoned.
- err_kbd  out  1  one-cycle pulse: keyboard error byte 0x00 or 0xFF received.
- err_ovf  out  1  sticky: an event was dropped because the FIFO was full.
- clr_err  in  1  synchronous clear of err_ovf.

Behaviour:
- Reset values: state IDLE, FIFO empty, timeout counter 0, enable_rx=0, ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, all error outputs 0.
- enable_rx is registered: 1 when FIFO count <= FIFO_DEPTH-2, else 0.
  - One slot stays reserved for a frame already in flight when enable drops.
  - enable_rx rises on the first clk after reset release.
- States: IDLE, GOT_E0, GOT_F0, GOT_E0F0. A byte is consumed only on a cycle with rx_listo=1.
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; 00/FF -> pulse err_kbd, stay; other byte -> push {code, ext=0, brk=0}.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> stay; 00/FF -> err_kbd, go to IDLE; other -> push {code, 1, 0}, go to IDLE.
  - GOT_F0: F0/E0 -> go to IDLE with err_kbd pulse; 00/FF -> err_kbd, go to IDLE; other -> push {code, 0, 1}, go to IDLE.
  - GOT_E0F0: prefix bytes or 00/FF -> err_kbd, go to IDLE; other -> push {code, 1, 1}, go to IDLE.
- Timeout counter:
  - Cleared in IDLE and on every consumed byte; increments every cycle in non-IDLE states.
  - On reaching TIMEOUT_CYC-1: go to IDLE, pulse err_timeout, clear counter.
  - If a byte arrives on the expiry cycle, the byte wins and no timeout is reported.
- FIFO:
  - Push latency: event pushed on an rx_listo cycle -> ev_valid=1 on the next cycle when the FIFO was empty.
  - Head outputs are stable while ev_valid=1 and ev_ready=0.
  - Pop occurs when ev_valid & ev_ready.
  - Push and pop in the same cycle: both execute, count unchanged; this also applies when full.
  - Push when full with no pop: event dropped, err_ovf set.
  - Pointers wrap modulo FIFO_DEPTH.
- err_ovf is cleared by clr_err; if a set and a clear occur in the same cycle, the set wins.
- Async reset mid-sequence discards any partial prefix and all FIFO contents.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined: a register holds the last pushed make event {code, ext}.
  - A new make event equal to it, with no intervening matching break, is discarded as typematic repeat; no push, no error.
  - A matching break clears the register; reset clears it.
- Undefined: every make event is pushed, including typematic repeats.

Decomposition:
- Shared package ps2_pkg:
  - State encoding constants.
  - Byte constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERRF=8'hFF.
  - Event record width (10 bits: {ext, brk, code}).
- Sub-module: ps2_evt_fifo. Generic synchronous FIFO with parameterised width and depth, providing count, full and empty.

Test Plan:
1. Release reset, send byte 0x1C, keep ev_ready=1 -> one event {1C, ext=0, brk=0}; ev_valid high for exactly 1 cycle.
2. Send E0, F0, 75 -> one event {75, ext=1, brk=1}; no event for the prefix bytes.
3. Send F0, then no byte for TIMEOUT_CYC cycles, then 1C -> err_timeout pulses once; then event {1C, 0, 0}.
4. Hold ev_ready=0 and send 5 make codes with FIFO_DEPTH=4:
   - enable_rx drops after the 3rd event.
   - The 5th byte is dropped and err_ovf=1.
   - Draining yields the first 4 codes in order; clr_err clears err_ovf.
5. Send 00, then FF -> two err_kbd pulses, no events.
6. With PS2_REPEAT_FILTER_EN defined, send 1C, 1C, 1C, F0 1C, 1C -> events: make 1C, break 1C, make 1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: FSM states,
// protocol byte values and the packed key-event record.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERRF = 8'hFF;

    localparam int EVT_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERRF);
    endfunction

endpackage

// File: rtl/ps2_scan_ctrl_if.sv
// Receiver-side and event-side handshake bundle of the scan sequencer.
// master = the sequencer, slave = receiver/consumer environment.
interface ps2_scan_ctrl_if;
    logic       rx_listo;
    logic [7:0] codigo_tecla;
    logic       enable_rx;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;

    modport master (
        input  rx_listo, codigo_tecla, ev_ready,
        output enable_rx, ev_valid, ev_code, ev_ext, ev_brk
    );

    modport slave (
        output rx_listo, codigo_tecla, ev_ready,
        input  enable_rx, ev_valid, ev_code, ev_ext, ev_brk
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO with count/full/empty; a push while full is only
// accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so a pushed entry is visible the next cycle;
    // forced to zero while empty so stale entries never leak out.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan sequencer: folds E0/F0 prefixes into key events and queues them.
// Optional typematic-repeat suppression when PS2_REPEAT_FILTER_EN is defined.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int TO_W        = 21
) (
    input  logic             clk,
    input  logic             rst,
    ps2_scan_ctrl_if.master  bus,
    output logic             err_timeout,
    output logic             err_kbd,
    output logic             err_ovf,
    input  logic             clr_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] EN_THRESH = CNT_W'(FIFO_DEPTH - 2);

    ps2_state_t       state_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             enable_reg;
    logic             err_timeout_reg;
    logic             err_kbd_reg;
    logic             err_ovf_reg;

    logic [7:0]       rx_byte;
    logic             is_ext;
    logic             is_brk;
    logic             is_err;
    logic             evt_req;
    ps2_evt_t         evt;
    logic             push;
    logic             pop;
    logic             ovf;
    ps2_evt_t         head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign rx_byte = bus.codigo_tecla;
    assign is_ext  = (rx_byte == PS2_EXT);
    assign is_brk  = (rx_byte == PS2_BRK);
    assign is_err  = is_err_byte(rx_byte);

    // Any non-prefix, non-error byte completes an event in every state;
    // the current state only decides its ext/brk flags.
    assign evt_req  = bus.rx_listo && !is_ext && !is_brk && !is_err;
    assign evt.code = rx_byte;
    assign evt.ext  = (state_reg == ST_GOT_E0) || (state_reg == ST_GOT_E0F0);
    assign evt.brk  = (state_reg == ST_GOT_F0) || (state_reg == ST_GOT_E0F0);

    assign pop = !fifo_empty && bus.ev_ready;
    assign ovf = push && fifo_full && !pop;

`ifdef PS2_REPEAT_FILTER_EN
    logic       rep_vld_reg;
    logic [8:0] rep_key_reg;
    logic       rep_match;

    assign rep_match = rep_vld_reg && (rep_key_reg == {evt.ext, evt.code});
    assign push      = evt_req && !(rep_match && !evt.brk);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_vld_reg <= 1'b0;
            rep_key_reg <= '0;
        end else if (evt_req && evt.brk && rep_match) begin
            rep_vld_reg <= 1'b0;
        end else if (push && !evt.brk && (!fifo_full || pop)) begin
            rep_vld_reg <= 1'b1;
            rep_key_reg <= {evt.ext, evt.code};
        end
    end
`else
    assign push = evt_req;
`endif

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (evt),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            to_cnt_reg      <= '0;
            enable_reg      <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_kbd_reg     <= 1'b0;
            err_ovf_reg     <= 1'b0;
        end else begin
            err_timeout_reg <= 1'b0;
            err_kbd_reg     <= 1'b0;
            enable_reg      <= (fifo_count <= EN_THRESH);

            if (ovf) begin
                err_ovf_reg <= 1'b1;
            end else if (clr_err) begin
                err_ovf_reg <= 1'b0;
            end

            // A consumed byte always takes priority over an expiring timeout.
            if (bus.rx_listo) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    ST_IDLE: begin
                        if (is_ext)      state_reg   <= ST_GOT_E0;
                        else if (is_brk) state_reg   <= ST_GOT_F0;
                        else if (is_err) err_kbd_reg <= 1'b1;
                    end
                    ST_GOT_E0: begin
                        if (is_brk) begin
                            state_reg <= ST_GOT_E0F0;
                        end else if (!is_ext) begin
                            err_kbd_reg <= is_err;
                            state_reg   <= ST_IDLE;
                        end
                    end
                    ST_GOT_F0, ST_GOT_E0F0: begin
                        err_kbd_reg <= is_err || is_ext || is_brk;
                        state_reg   <= ST_IDLE;
                    end
                endcase
            end else if (state_reg == ST_IDLE) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg == TO_LIMIT) begin
                state_reg       <= ST_IDLE;
                err_timeout_reg <= 1'b1;
                to_cnt_reg      <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.enable_rx = enable_reg;
    assign bus.ev_valid  = !fifo_empty;
    assign bus.ev_code   = head.code;
    assign bus.ev_ext    = head.ext;
    assign bus.ev_brk    = head.brk;
    assign err_timeout   = err_timeout_reg;
    assign err_kbd       = err_kbd_reg;
    assign err_ovf       = err_ovf_reg;
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl with a short timeout; the repeat-filter
// scenario adapts its expectations to PS2_REPEAT_FILTER_EN.
module tb_ps2_scan_ctrl;
    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic clk;
    logic rst;
    logic err_timeout;
    logic err_kbd;
    logic err_ovf;
    logic clr_err;

    int chk;
    int fails;
    int n_to;
    int n_kbd;
    logic [9:0] evq[$];

    ps2_scan_ctrl_if bus();

    ps2_scan_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO),
        .TO_W        (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_timeout (err_timeout),
        .err_kbd     (err_kbd),
        .err_ovf     (err_ovf),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record popped events and error pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.ev_valid && bus.ev_ready) evq.push_back({bus.ev_ext, bus.ev_brk, bus.ev_code});
        if (err_timeout) n_to++;
        if (err_kbd) n_kbd++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        $display("rx byte %02h ready=%0b", b, bus.ev_ready);
        bus.codigo_tecla = b;
        bus.rx_listo     = 1'b1;
        tick();
        bus.rx_listo     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(2);
        chk++; if (bus.enable_rx !== 1'b0) begin fails++; $display("FAIL rst_enable: got %b expected 0", bus.enable_rx); end
        chk++; if (bus.ev_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", bus.ev_valid); end
        chk++; if ({bus.ev_ext, bus.ev_brk, bus.ev_code} !== 10'h000) begin fails++; $display("FAIL rst_head: got %h expected 000", {bus.ev_ext, bus.ev_brk, bus.ev_code}); end
        chk++; if ({err_timeout, err_kbd, err_ovf} !== 3'b000) begin fails++; $display("FAIL rst_errs: got %b expected 000", {err_timeout, err_kbd, err_ovf}); end
        rst = 1'b1;
        chk++; if (bus.enable_rx !== 1'b0) begin fails++; $display("FAIL rst_enable_release: got %b expected 0", bus.enable_rx); end
        tick();
        chk++; if (bus.enable_rx !== 1'b1) begin fails++; $display("FAIL rst_enable_first_clk: got %b expected 1", bus.enable_rx); end
    endtask

    task automatic test_make;
        evq.delete();
        bus.ev_ready = 1'b1;
        send_byte(8'h1C);
        chk++; if (bus.ev_valid !== 1'b1) begin fails++; $display("FAIL make_valid: got %b expected 1", bus.ev_valid); end
        chk++; if ({bus.ev_ext, bus.ev_brk, bus.ev_code} !== 10'h01C) begin fails++; $display("FAIL make_head: got %h expected 01C", {bus.ev_ext, bus.ev_brk, bus.ev_code}); end
        tick();
        chk++; if (bus.ev_valid !== 1'b0) begin fails++; $display("FAIL make_valid_one_cycle: got %b expected 0", bus.ev_valid); end
        chk++; if (evq.size() !== 1) begin fails++; $display("FAIL make_count: got %0d expected 1", evq.size()); end
    endtask

    task automatic test_ext_break;
        evq.delete();
        send_byte(8'hE0);
        chk++; if (bus.ev_valid !== 1'b0) begin fails++; $display("FAIL ext_prefix_e0: got %b expected 0", bus.ev_valid); end
        send_byte(8'hF0);
        chk++; if (bus.ev_valid !== 1'b0) begin fails++; $display("FAIL ext_prefix_f0: got %b expected 0", bus.ev_valid); end
        send_byte(8'h75);
        tick(3);
        chk++; if (evq.size() !== 1) begin fails++; $display("FAIL ext_count: got %0d expected 1", evq.size()); end
        else begin
            chk++; if (evq[0] !== 10'h375) begin fails++; $display("FAIL ext_event: got %h expected 375", evq[0]); end
        end
    endtask

    task automatic test_timeout;
        int to0;
        evq.delete();
        to0 = n_to;
        send_byte(8'hF0);
        tick(TO - 1);
        chk++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL to_early: got %b expected 0", err_timeout); end
        tick();
        chk++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b expected 1", err_timeout); end
        tick(3);
        chk++; if (n_to - to0 !== 1) begin fails++; $display("FAIL to_pulse_count: got %0d expected 1", n_to - to0); end
        send_byte(8'h1B);
        tick(3);
        chk++; if (evq.size() !== 1) begin fails++; $display("FAIL to_evt_count: got %0d expected 1", evq.size()); end
        else begin
            chk++; if (evq[0] !== 10'h01B) begin fails++; $display("FAIL to_event: got %h expected 01B", evq[0]); end
        end
    endtask

    task automatic test_expiry_byte_wins;
        int to0;
        evq.delete();
        to0 = n_to;
        send_byte(8'hE0);
        tick(TO - 1);
        send_byte(8'h6B);
        tick(TO + 3);
        chk++; if (n_to - to0 !== 0) begin fails++; $display("FAIL expiry_no_timeout: got %0d expected 0", n_to - to0); end
        chk++; if (evq.size() !== 1) begin fails++; $display("FAIL expiry_count: got %0d expected 1", evq.size()); end
        else begin
            chk++; if (evq[0] !== 10'h26B) begin fails++; $display("FAIL expiry_event: got %h expected 26B", evq[0]); end
        end
    endtask

    task automatic test_kbd_err;
        int k0;
        evq.delete();
        k0 = n_kbd;
        send_byte(8'h00);
        chk++; if (err_kbd !== 1'b1) begin fails++; $display("FAIL kbd_pulse00: got %b expected 1", err_kbd); end
        tick();
        chk++; if (err_kbd !== 1'b0) begin fails++; $display("FAIL kbd_pulse_end: got %b expected 0", err_kbd); end
        send_byte(8'hFF);
        tick(3);
        chk++; if (n_kbd - k0 !== 2) begin fails++; $display("FAIL kbd_count: got %0d expected 2", n_kbd - k0); end
        chk++; if (evq.size() !== 0) begin fails++; $display("FAIL kbd_no_events: got %0d expected 0", evq.size()); end
    endtask

    task automatic test_overflow;
        logic [9:0] exp_q[$];
        exp_q = '{10'h015, 10'h01D, 10'h024, 10'h02D};
        evq.delete();
        bus.ev_ready = 1'b0;
        send_byte(8'h15);
        send_byte(8'h1D);
        send_byte(8'h24);
        chk++; if (bus.enable_rx !== 1'b1) begin fails++; $display("FAIL ovf_enable_3rd: got %b expected 1", bus.enable_rx); end
        tick();
        chk++; if (bus.enable_rx !== 1'b0) begin fails++; $display("FAIL ovf_enable_drop: got %b expected 0", bus.enable_rx); end
        send_byte(8'h2D);
        chk++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b expected 0", err_ovf); end
        send_byte(8'h2C);
        chk++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", err_ovf); end
        chk++; if (bus.ev_code !== 8'h15) begin fails++; $display("FAIL ovf_head_stable: got %h expected 15", bus.ev_code); end
        bus.ev_ready = 1'b1;
        tick(6);
        chk++; if (evq.size() !== 4) begin fails++; $display("FAIL ovf_drain_count: got %0d expected 4", evq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                chk++; if (evq[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, evq[i], exp_q[i]); end
            end
        end
        chk++; if (bus.enable_rx !== 1'b1) begin fails++; $display("FAIL ovf_enable_back: got %b expected 1", bus.enable_rx); end
        chk++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", err_ovf); end
    endtask

    task automatic test_full_push_pop;
        logic [9:0] exp_q[$];
        exp_q = '{10'h043, 10'h044, 10'h04B, 10'h04C, 10'h04D};
        evq.delete();
        bus.ev_ready = 1'b0;
        send_byte(8'h43);
        send_byte(8'h44);
        send_byte(8'h4B);
        send_byte(8'h4C);
        bus.ev_ready = 1'b1;
        send_byte(8'h4D);
        chk++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL fpp_no_ovf: got %b expected 0", err_ovf); end
        chk++; if (bus.ev_code !== 8'h44) begin fails++; $display("FAIL fpp_head: got %h expected 44", bus.ev_code); end
        tick(6);
        chk++; if (evq.size() !== 5) begin fails++; $display("FAIL fpp_count: got %0d expected 5", evq.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                chk++; if (evq[i] !== exp_q[i]) begin fails++; $display("FAIL fpp_evt_%0d: got %h expected %h", i, evq[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_repeat;
        logic [9:0] exp_q[$];
`ifdef PS2_REPEAT_FILTER_EN
        exp_q = '{10'h01C, 10'h11C, 10'h01C};
`else
        exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        evq.delete();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        tick(4);
        chk++; if (evq.size() !== exp_q.size()) begin fails++; $display("FAIL rep_count: got %0d expected %0d", evq.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                chk++; if (evq[i] !== exp_q[i]) begin fails++; $display("FAIL rep_evt_%0d: got %h expected %h", i, evq[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_async_reset;
        bus.ev_ready = 1'b0;
        send_byte(8'h21);
        send_byte(8'hE0);
        #2 rst = 1'b0;
        #1;
        chk++; if (bus.ev_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b expected 0", bus.ev_valid); end
        chk++; if (bus.enable_rx !== 1'b0) begin fails++; $display("FAIL arst_enable: got %b expected 0", bus.enable_rx); end
        tick();
        rst = 1'b1;
        tick();
        evq.delete();
        bus.ev_ready = 1'b1;
        send_byte(8'h75);
        tick(3);
        chk++; if (evq.size() !== 1) begin fails++; $display("FAIL arst_count: got %0d expected 1", evq.size()); end
        else begin
            chk++; if (evq[0] !== 10'h075) begin fails++; $display("FAIL arst_event: got %h expected 075", evq[0]); end
        end
    endtask

    initial begin
        chk = 0;
        fails = 0;
        n_to = 0;
        n_kbd = 0;
        rst = 1'b0;
        clr_err = 1'b0;
        bus.rx_listo = 1'b0;
        bus.codigo_tecla = 8'h00;
        bus.ev_ready = 1'b0;
        test_reset();
        test_make();
        test_ext_break();
        test_timeout();
        test_expiry_byte_wins();
        test_kbd_err();
        test_overflow();
        test_full_push_pop();
        test_repeat();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
